// File: rtl/mul_issue_unit.sv
// mul_issue_unit: issue/writeback sequencer for the RV32M multiply path in front of
// mul32x32_pipelined. All state updates on the falling edge of clk_i.
// Optional feature: define MUL_ISSUE_FLUSH_EN to add flush_i and per-entry kill bits.
module mul_issue_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
`ifdef MUL_ISSUE_FLUSH_EN
  input  logic              flush_i,
`endif
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic [1:0]        op_funct_i,
  input  logic [XLEN-1:0]   op_rs1_i,
  input  logic [XLEN-1:0]   op_rs2_i,
  input  logic [4:0]        op_rd_i,
  output logic              mul_start_o,
  output logic              mul_signed_o,
  output logic [XLEN-1:0]   mul_x_o,
  output logic [XLEN-1:0]   mul_y_o,
  input  logic              mul_rdy_i,
  input  logic [2*XLEN-1:0] mul_result_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [4:0]        wb_rd_o,
  output logic [XLEN-1:0]   wb_data_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned AW = PW + 1;
  localparam int unsigned CW = PW + 2;

  localparam logic [1:0] FN_MUL    = 2'b00;
  localparam logic [1:0] FN_MULH   = 2'b01;
  localparam logic [1:0] FN_MULHSU = 2'b10;

  // metadata FIFO (in flight) and result FIFO (awaiting writeback)
  logic [1:0]      meta_funct [DEPTH];
  logic [4:0]      meta_rd    [DEPTH];
  logic [XLEN-1:0] meta_corr  [DEPTH];
  logic [4:0]      res_rd     [DEPTH];
  logic [XLEN-1:0] res_data   [DEPTH];

  logic [AW-1:0]   meta_wp, meta_rp, res_wp, res_rp;
  logic [AW-1:0]   meta_wp_n, meta_rp_n, res_wp_n, res_rp_n;
  logic [CW-1:0]   count_n;
  logic [PW-1:0]   meta_head;
  logic            accept, capture, killed, res_push, wb_pop, flush;
  logic [XLEN-1:0] new_corr, cap_data, head_data_n;
  logic [4:0]      head_rd_n;

`ifdef MUL_ISSUE_FLUSH_EN
  logic [DEPTH-1:0] kill;
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // handshakes, result word selection and next FIFO state
  always_comb begin
    accept    = op_valid_i && op_ready_o && !flush;
    capture   = mul_rdy_i && (meta_wp != meta_rp);
    meta_head = meta_rp[PW-1:0];
`ifdef MUL_ISSUE_FLUSH_EN
    killed    = kill[meta_head] || flush;
`else
    killed    = 1'b0;
`endif
    res_push  = capture && !killed;
    wb_pop    = wb_valid_o && wb_ready_i;

    // signed x signed hi word plus rs1 turns it into signed x unsigned when rs2 is negative
    new_corr  = ((op_funct_i == FN_MULHSU) && op_rs2_i[XLEN-1]) ? op_rs1_i : '0;

    cap_data  = mul_result_i[2*XLEN-1:XLEN];
    case (meta_funct[meta_head])
      FN_MUL:    cap_data = mul_result_i[XLEN-1:0];
      FN_MULHSU: cap_data = mul_result_i[2*XLEN-1:XLEN] + meta_corr[meta_head];
      default:   cap_data = mul_result_i[2*XLEN-1:XLEN];
    endcase

    meta_wp_n = meta_wp + AW'(accept);
    meta_rp_n = meta_rp + AW'(capture);
    res_wp_n  = res_wp + AW'(res_push);
    res_rp_n  = flush ? res_wp_n : (res_rp + AW'(wb_pop));
    count_n   = CW'(meta_wp_n - meta_rp_n) + CW'(res_wp_n - res_rp_n);

    // next head of the result FIFO, bypassing a push that lands in the head slot
    head_rd_n   = '0;
    head_data_n = '0;
    if (res_wp_n != res_rp_n) begin
      if (res_push && (res_wp[PW-1:0] == res_rp_n[PW-1:0])) begin
        head_rd_n   = meta_rd[meta_head];
        head_data_n = cap_data;
      end else begin
        head_rd_n   = res_rd[res_rp_n[PW-1:0]];
        head_data_n = res_data[res_rp_n[PW-1:0]];
      end
    end
  end

  // control state and registered outputs
  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      meta_wp      <= '0;
      meta_rp      <= '0;
      res_wp       <= '0;
      res_rp       <= '0;
      op_ready_o   <= 1'b0;
      mul_start_o  <= 1'b0;
      mul_signed_o <= 1'b0;
      mul_x_o      <= '0;
      mul_y_o      <= '0;
      wb_valid_o   <= 1'b0;
      wb_rd_o      <= '0;
      wb_data_o    <= '0;
    end else begin
      meta_wp     <= meta_wp_n;
      meta_rp     <= meta_rp_n;
      res_wp      <= res_wp_n;
      res_rp      <= res_rp_n;
      op_ready_o  <= (count_n < CW'(DEPTH)) && !flush;
      mul_start_o <= accept;
      if (accept) begin
        mul_signed_o <= (op_funct_i == FN_MULH) || (op_funct_i == FN_MULHSU);
        mul_x_o      <= op_rs1_i;
        mul_y_o      <= op_rs2_i;
      end
      wb_valid_o  <= (res_wp_n != res_rp_n);
      wb_rd_o     <= head_rd_n;
      wb_data_o   <= head_data_n;
    end
  end

  // FIFO storage; validity is carried entirely by the pointers
  always_ff @(negedge clk_i) begin
    if (accept) begin
      meta_funct[meta_wp[PW-1:0]] <= op_funct_i;
      meta_rd[meta_wp[PW-1:0]]    <= op_rd_i;
      meta_corr[meta_wp[PW-1:0]]  <= new_corr;
    end
    if (res_push) begin
      res_rd[res_wp[PW-1:0]]   <= meta_rd[meta_head];
      res_data[res_wp[PW-1:0]] <= cap_data;
    end
  end

`ifdef MUL_ISSUE_FLUSH_EN
  // kill bits: every entry outstanding at a flush returns its credit without a result
  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      kill <= '0;
    end else if (flush_i) begin
      kill <= '1;
    end else if (accept) begin
      kill[meta_wp[PW-1:0]] <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_mul_issue_unit.sv
// tb_mul_issue_unit: self-checking bench for mul_issue_unit with a behavioural multiplier.
module tb_mul_issue_unit;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int          LAT   = 3;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [1:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] d;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        op_valid, op_ready;
  logic [1:0]  op_funct;
  logic [31:0] op_rs1, op_rs2;
  logic [4:0]  op_rd;
  logic        mul_start, mul_signed;
  logic [31:0] mul_x, mul_y;
  logic        mul_rdy;
  logic [63:0] mul_result;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_total = 0;
  int n_pass  = 0;

  exp_t        sb[$];
  logic [4:0]  pop_log[$];
  logic [31:0] pop_dlog[$];

  logic        pv [LAT];
  logic [63:0] pp [LAT];

  mul_issue_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
`ifdef MUL_ISSUE_FLUSH_EN
    .flush_i      (flush),
`endif
    .op_valid_i   (op_valid),
    .op_ready_o   (op_ready),
    .op_funct_i   (op_funct),
    .op_rs1_i     (op_rs1),
    .op_rs2_i     (op_rs2),
    .op_rd_i      (op_rd),
    .mul_start_o  (mul_start),
    .mul_signed_o (mul_signed),
    .mul_x_o      (mul_x),
    .mul_y_o      (mul_y),
    .mul_rdy_i    (mul_rdy),
    .mul_result_i (mul_result),
    .wb_valid_o   (wb_valid),
    .wb_ready_i   (wb_ready),
    .wb_rd_o      (wb_rd),
    .wb_data_o    (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // product as the multiplier hardware forms it: both operands signed or both unsigned
  function automatic logic [63:0] mult_hw(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] ex, ey;
    ex = sgn ? {{32{x[31]}}, x} : {32'h0, x};
    ey = sgn ? {{32{y[31]}}, y} : {32'h0, y};
    return ex * ey;
  endfunction

  // architectural result of an RV32M multiply
  function automatic logic [31:0] ref_result(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb_, ua, ub;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    case (f)
      2'd0:    p = sa * sb_;
      2'd1:    p = sa * sb_;
      2'd2:    p = sa * ub;
      default: p = ua * ub;
    endcase
    return (f == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // fixed-latency pipelined multiplier; it has no reset, so pre-reset ops still pulse
  always @(posedge clk) begin
    mul_rdy    = pv[LAT-1];
    mul_result = pp[LAT-1];
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pp[i] = pp[i-1];
    end
    pv[0] = (mul_start === 1'b1);
    pp[0] = mult_hw(mul_signed, mul_x, mul_y);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // one cycle: sample outputs at the rising edge, score handshakes, drive new inputs
  task automatic step(input bit v, input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input bit wbr, input bit r, input bit fl, output bit acc);
    exp_t e;
    @(posedge clk);
    acc = v && (op_ready === 1'b1) && !r && !fl;
    if ((wb_valid === 1'b1) && wbr && !r && !fl) begin
      pop_log.push_back(wb_rd);
      pop_dlog.push_back(wb_data);
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h expected no result", wb_rd, wb_data);
      end else begin
        e = sb.pop_front();
        chk("wb_rd", 64'(wb_rd), 64'(e.rd));
        chk("wb_data", 64'(wb_data), 64'(e.data));
      end
    end
    if (r || fl) sb.delete();
    if (acc) sb.push_back('{rd, ref_result(f, a, b)});
    rst      = r;
    flush    = fl;
    op_valid = v;
    op_funct = f;
    op_rs1   = a;
    op_rs2   = b;
    op_rd    = rd;
    wb_ready = wbr;
  endtask

  task automatic idle(input bit wbr);
    bit acc;
    step(1'b0, 2'd0, 32'h0, 32'h0, 5'd0, wbr, 1'b0, 1'b0, acc);
  endtask

  task automatic issue_wait(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input bit wbr);
    bit acc;
    acc = 1'b0;
    for (int c = 0; c < 20 && !acc; c++) step(1'b1, f, a, b, rd, wbr, 1'b0, 1'b0, acc);
    if (!acc) begin
      n_total++;
      $display("FAIL issue_timeout: got no acceptance expected acceptance within 20 cycles");
    end
  endtask

  task automatic run_vec(input string name, input vec_t t, input logic [4:0] rd);
    pop_dlog.delete();
    issue_wait(t.f, t.a, t.b, rd, 1'b1);
    idle(1'b1);
    chk({name, "_start"}, 64'(mul_start), 64'd1);
    chk({name, "_signed"}, 64'(mul_signed), 64'(t.sgn));
    chk({name, "_x"}, 64'(mul_x), 64'(t.a));
    chk({name, "_y"}, 64'(mul_y), 64'(t.b));
    idle(1'b1);
    chk({name, "_start_pulse"}, 64'(mul_start), 64'd0);
    for (int c = 0; c < 20 && pop_dlog.size() == 0; c++) idle(1'b1);
    if (pop_dlog.size() == 0) begin
      n_total++;
      $display("FAIL %s_timeout: got no writeback expected data %h", name, t.d);
    end else begin
      chk({name, "_data"}, 64'(pop_dlog[0]), 64'(t.d));
    end
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  vec_t vecs[8];

  initial begin
    bit acc;
    int n_acc;

    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pp[i] = 64'h0;
    end
    rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op_funct = 2'd0;
    op_rs1 = 32'h0; op_rs2 = 32'h0; op_rd = 5'd0; wb_ready = 1'b0;
    mul_rdy = 1'b0; mul_result = 64'h0;

    vecs[0] = '{2'd0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFEB};
    vecs[1] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000};
    vecs[2] = '{2'd3, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000};
    vecs[3] = '{2'd2, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'hC000_0000};
    vecs[4] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF};
    vecs[5] = '{2'd0, 32'h0000_0003, 32'h0000_0005, 1'b0, 32'h0000_000F};
    vecs[6] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'h0000_0001};
    vecs[7] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000};

    // reset state
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, acc);
    chk("rst_op_ready", 64'(op_ready), 64'd0);
    chk("rst_mul_start", 64'(mul_start), 64'd0);
    chk("rst_mul_signed", 64'(mul_signed), 64'd0);
    chk("rst_mul_x", 64'(mul_x), 64'd0);
    chk("rst_mul_y", 64'(mul_y), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    idle(1'b0);
    idle(1'b0);
    chk("post_rst_ready", 64'(op_ready), 64'd1);

    // directed vectors, one at a time
    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i], 5'(i + 3));

    // backpressure: four fill the unit, the fifth is held until writeback drains
    pop_log.delete();
    for (int k = 1; k <= 4; k++) issue_wait(2'(k % 4), 32'h1111 * k, 32'hFFFF_0000 + k, 5'(k), 1'b0);
    n_acc = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 2'd2, 32'h8000_0001, 32'hFFFF_FFF0, 5'd5, 1'b0, 1'b0, 1'b0, acc);
      if (acc) n_acc++;
    end
    chk("full_ready_low", 64'(op_ready), 64'd0);
    chk("full_fifth_held", 64'(n_acc), 64'd0);
    issue_wait(2'd2, 32'h8000_0001, 32'hFFFF_FFF0, 5'd5, 1'b1);
    for (int c = 0; c < 30 && pop_log.size() < 5; c++) idle(1'b1);
    chk("bp_pop_count", 64'(pop_log.size()), 64'd5);
    for (int k = 0; k < 5 && k < pop_log.size(); k++) chk("bp_order_rd", 64'(pop_log[k]), 64'(k + 1));

    // reset with two ops in flight; their multiplier pulses must be dropped
    issue_wait(2'd0, 32'h2, 32'h3, 5'd7, 1'b0);
    issue_wait(2'd0, 32'h4, 32'h5, 5'd8, 1'b0);
    step(1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, acc);
    for (int i = 0; i < 6; i++) begin
      idle(1'b1);
      chk("stale_wb_valid", 64'(wb_valid), 64'd0);
      if (i > 0) chk("stale_ready", 64'(op_ready), 64'd1);
    end
    run_vec("after_rst", vecs[5], 5'd9);

    // randomized traffic against the scoreboard
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), rnd32(), rnd32(),
           5'($urandom_range(0, 31)), $urandom_range(0, 9) < 7, 1'b0, 1'b0, acc);
    end
    for (int c = 0; c < 60 && sb.size() != 0; c++) idle(1'b1);
    chk("drain_empty", 64'(sb.size()), 64'd0);

`ifdef MUL_ISSUE_FLUSH_EN
    // flush: one result buffered, three in flight, none may reach writeback
    issue_wait(2'd0, 32'h2, 32'h2, 5'd20, 1'b0);
    for (int i = 0; i < 6; i++) idle(1'b0);
    chk("fl_buffered", 64'(wb_valid), 64'd1);
    for (int k = 0; k < 3; k++) issue_wait(2'd1, 32'h10 + k, 32'h20, 5'(21 + k), 1'b0);
    step(1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, acc);
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      idle(1'b1);
      if (i == 0) chk("fl_ready_low", 64'(op_ready), 64'd0);
      chk("fl_wb_valid", 64'(wb_valid), 64'd0);
      if (op_ready === 1'b1) n_acc = 1;
    end
    chk("fl_ready_back", 64'(n_acc), 64'd1);
    run_vec("after_flush", vecs[6], 5'd25);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
